// File: rtl/idct_dot_pipe_if.sv
// Stream bundle for the IDCT dot-product stage: input beat handshake plus
// the result handshake that carries acc/d/x for downstream butterflies.
interface idct_dot_pipe_if #(
   parameter int N_TAPS = 4,
   parameter int DIN_W  = 16,
   parameter int ACC_W  = 26,
   parameter int DOUT_W = 16
) ();
   logic                       in_valid;
   logic                       in_ready;
   logic [N_TAPS*DIN_W-1:0]    d_in;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [ACC_W-1:0]    acc_out;
   logic signed [DOUT_W-1:0]   d_out;
   logic [N_TAPS*DIN_W-1:0]    x_out;

   modport master (
      output in_valid, d_in, out_ready,
      input  in_ready, out_valid, acc_out, d_out, x_out
   );

   modport slave (
      input  in_valid, d_in, out_ready,
      output in_ready, out_valid, acc_out, d_out, x_out
   );
endinterface

// File: rtl/idct_dot_pipe.sv
// N-tap systolic dot product with internal input skew, programmable
// coefficients, whole-pipeline stall and rounded/saturated output.
module idct_dot_pipe #(
   parameter int N_TAPS = 4,
   parameter int DIN_W  = 16,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 26,
   parameter int DOUT_W = 16,
   parameter int SHIFT  = 7,
   parameter logic [N_TAPS*COEF_W-1:0] COEF_INIT = {8'sd83, -8'sd64, -8'sd36, 8'sd64},
   localparam int AW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   idct_dot_pipe_if.slave           bus
);

   localparam int PW     = DIN_W + COEF_W;
   localparam int VW     = N_TAPS * DIN_W;
   localparam int EW     = ACC_W + 1;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [EW-1:0] RND_C = (SHIFT > 0) ?
      ({{(EW-1){1'b0}}, 1'b1} << RND_SH) : {EW{1'b0}};
   localparam logic signed [EW-1:0] DMAX = {{(EW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
   localparam logic signed [EW-1:0] DMIN = {{(EW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

   logic signed [COEF_W-1:0] c_r    [N_TAPS];
   logic [N_TAPS-1:0]        vld_r;
   logic signed [ACC_W-1:0]  p_r    [N_TAPS];
   logic [VW-1:0]            xv_r   [N_TAPS];
   logic signed [ACC_W-1:0]  prod_s [N_TAPS];
   logic signed [EW-1:0]     rnd_s;
   logic                     adv_s;

   function automatic logic signed [ACC_W-1:0] mul_ext(
      input logic signed [DIN_W-1:0]  x,
      input logic signed [COEF_W-1:0] c
   );
      logic signed [PW-1:0] m;
      m = PW'(x) * PW'(c);
      return ACC_W'(m);
   endfunction

   function automatic logic signed [DOUT_W-1:0] sat(input logic signed [EW-1:0] v);
      logic signed [DOUT_W-1:0] r;
      if (v > DMAX) begin
         r = DMAX[DOUT_W-1:0];
      end else if (v < DMIN) begin
         r = DMIN[DOUT_W-1:0];
      end else begin
         r = v[DOUT_W-1:0];
      end
      return r;
   endfunction

   assign adv_s = ~vld_r[N_TAPS-1] | bus.out_ready;

   // Per-tap products; tap k reads lane k after k skew registers.
   always_comb begin
      prod_s[0] = mul_ext(bus.d_in[DIN_W-1:0], c_r[0]);
      for (int k = 1; k < N_TAPS; k++) begin
         prod_s[k] = mul_ext(xv_r[k-1][k*DIN_W +: DIN_W], c_r[k]);
      end
   end

   // Round-half-up then arithmetic shift of the registered accumulator.
   always_comb begin
      rnd_s = (EW'(p_r[N_TAPS-1]) + RND_C) >>> SHIFT;
   end

   // Systolic partial sums, valid chain and the vector delay line; the
   // vector line doubles as the per-lane skew and the x_out alignment.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_r <= '0;
         for (int s = 0; s < N_TAPS; s++) begin
            p_r[s]  <= '0;
            xv_r[s] <= '0;
         end
      end else if (adv_s) begin
         vld_r   <= {vld_r[N_TAPS-2:0], bus.in_valid};
         p_r[0]  <= prod_s[0];
         xv_r[0] <= bus.d_in;
         for (int s = 1; s < N_TAPS; s++) begin
            p_r[s]  <= p_r[s-1] + prod_s[s];
            xv_r[s] <= xv_r[s-1];
         end
      end
   end

   // Coefficient registers; writes ignore the stall and out-of-range taps.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N_TAPS; k++) begin
            c_r[k] <= COEF_INIT[k*COEF_W +: COEF_W];
         end
      end else if (coef_we && (int'(coef_addr) < N_TAPS)) begin
         c_r[coef_addr] <= coef_data;
      end
   end

   assign bus.in_ready  = adv_s;
   assign bus.out_valid = vld_r[N_TAPS-1];
   assign bus.acc_out   = p_r[N_TAPS-1];
   assign bus.x_out     = xv_r[N_TAPS-1];
   assign bus.d_out     = sat(rnd_s);

endmodule

// File: tb/tb_idct_dot_pipe.sv
// Scoreboard bench for idct_dot_pipe: expected results are modelled at
// acceptance time and compared whenever the DUT presents a result.
module tb_idct_dot_pipe;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = 8;
   localparam int AC = 26;
   localparam int OW = 16;
   localparam int SH = 7;

   typedef struct {
      longint      acc;
      longint      d;
      logic [63:0] x;
      longint      t;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 coef_we;
   logic [1:0]           coef_addr;
   logic signed [CW-1:0] coef_data;

   exp_t   sb[$];
   longint mc[N];
   longint cyc = 0;
   int     n_checks = 0;
   int     n_pass = 0;
   bit     mon_on = 1'b0;
   bit     lat_on = 1'b0;
   bit     rand_rdy = 1'b0;

   idct_dot_pipe_if #(.N_TAPS(N), .DIN_W(DW), .ACC_W(AC), .DOUT_W(OW)) bus ();

   idct_dot_pipe #(
      .N_TAPS(N), .DIN_W(DW), .COEF_W(CW), .ACC_W(AC), .DOUT_W(OW), .SHIFT(SH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .coef_we(coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [63:0] v, input longint t);
      exp_t e;
      longint s, a, r;
      logic signed [DW-1:0] xs;
      s = 0;
      for (int k = 0; k < N; k++) begin
         xs = v[k*DW +: DW];
         s += longint'(xs) * mc[k];
      end
      a = s & 64'sh3FFFFFF;
      if (a >= 64'sd33554432) a -= 64'sd67108864;
      r = (a + 64'sd64) >>> 7;
      if (r > 64'sd32767) r = 64'sd32767;
      else if (r < -64'sd32768) r = -64'sd32768;
      e.acc = a; e.d = r; e.x = v; e.t = t;
      return e;
   endfunction

   function automatic logic [63:0] vec(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] v);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.d_in     = v;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(model(v, cyc));
            ok = 1'b1;
         end
         tick();
      end
      bus.in_valid = 1'b0;
      if (!ok) check("send_timeout", 64'sd0, 64'sd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      check("drain", longint'(sb.size()), 64'sd0);
      tick();
      tick();
   endtask

   task automatic wcoef(input int a, input int val);
      coef_we   = 1'b1;
      coef_addr = 2'(a);
      coef_data = 8'(val);
      tick();
      coef_we   = 1'b0;
      mc[a]     = longint'(val);
   endtask

   // Output monitor: every presented result must match the queue head.
   always @(negedge clk) begin
      if (mon_on && !reset) begin
         check("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", longint'(bus.out_valid), 64'sd0);
            end else begin
               check("acc_out", longint'(bus.acc_out), sb[0].acc);
               check("d_out", longint'(bus.d_out), sb[0].d);
               check("x_out", longint'(bus.x_out), longint'(sb[0].x));
               if (bus.out_ready) begin
                  if (lat_on) check("latency", cyc - sb[0].t, 64'sd4);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         tick();
         if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
         else bus.out_ready = 1'b1;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; coef_we = 1'b0; coef_addr = 2'd0; coef_data = 8'sd0;
      bus.in_valid = 1'b0; bus.d_in = '0;
      mc = '{64, -36, -64, 83};
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", longint'(bus.out_valid), 64'sd0);
      check("rst_in_ready", longint'(bus.in_ready), 64'sd1);
      check("rst_acc_out", longint'(bus.acc_out), 64'sd0);
      check("rst_d_out", longint'(bus.d_out), 64'sd0);
      check("rst_x_out", longint'(bus.x_out), 64'sd0);
      tick();
      mon_on = 1'b1;
      lat_on = 1'b1;

      // one-hot lanes read the reset coefficients back through acc_out
      for (int k = 0; k < N; k++) send(64'd1 << (k*DW));
      wait_idle();

      send(vec(100, 0, 0, 0));
      wait_idle();
      send(vec(-100, 0, 0, 0));
      wait_idle();

      for (int i = 1; i <= 20; i++) send(vec(i, i, i, i));
      wait_idle();

      lat_on = 1'b0;
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) send({32'($urandom), 32'($urandom)});
      wait_idle();
      rand_rdy = 1'b0;
      tick();
      tick();
      lat_on = 1'b1;

      for (int k = 0; k < N; k++) wcoef(k, k + 1);
      send(vec(10, 20, 30, 40));
      wait_idle();

      for (int k = 0; k < N; k++) wcoef(k, -128);
      send(vec(-32768, -32768, -32768, -32768));
      wait_idle();
      for (int k = 0; k < N; k++) wcoef(k, 127);
      send(vec(-32768, -32768, -32768, -32768));
      wait_idle();

      // reset mid-stream, with a coefficient write that reset must override
      for (int i = 1; i <= 3; i++) send(vec(i * 7, i, -i, 3));
      reset = 1'b1;
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd5;
      tick();
      reset = 1'b0;
      coef_we = 1'b0;
      sb.delete();
      mc = '{64, -36, -64, 83};
      @(negedge clk);
      check("mid_rst_out_valid", longint'(bus.out_valid), 64'sd0);
      check("mid_rst_in_ready", longint'(bus.in_ready), 64'sd1);
      check("mid_rst_acc_out", longint'(bus.acc_out), 64'sd0);
      tick();
      send(vec(100, 0, 0, 0));
      wait_idle();
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
